// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Carry-chained adder split into STAGES equal chunks of CW = WIDTH/STAGES
//   bits. Stage k adds chunk k of the operands plus the carry registered by
//   stage k-1, and passes the not-yet-added upper operand chunks forward.
//   All stages advance together under a single enable. That enable is low
//   only while the output holds a result the consumer has not taken, so
//   bubbles are kept in place rather than collapsed.
//
//   Optional feature: define PIPE_ADDER_SAT_EN to saturate sum to the signed
//   limit on signed overflow. cout and of keep their unsaturated values.
//
// Parameters
//   WIDTH     operand/sum width (default 32)
//   STAGES    pipeline depth, WIDTH % STAGES == 0 (default 4)
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   a, b      operands (two's complement)
//   cin       carry-in
//   in_valid  / in_ready   input handshake (in_ready = advance enable)
//   sum       result, cout unsigned carry-out, of signed overflow
//   out_valid / out_ready  output handshake
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = WIDTH / STAGES;

  // Per-stage registers: forwarded operands, partial sum, carry, valid.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;
  logic              of_q, of_d;

  logic              en;
  logic [WIDTH-1:0]  op_a, op_b, part_s;
  logic              carry_in, valid_in;
  logic [CW:0]       chunk;
  logic              msb_carry_in;

  always_comb begin
    en           = !v_q[STAGES-1] || out_ready;
    op_a         = '0;
    op_b         = '0;
    part_s       = '0;
    carry_in     = 1'b0;
    valid_in     = 1'b0;
    chunk        = '0;
    c_d          = '0;
    v_d          = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        op_a     = a;
        op_b     = b;
        part_s   = '0;
        carry_in = cin;
        valid_in = in_valid;
      end else begin
        op_a     = a_q[k-1];
        op_b     = b_q[k-1];
        part_s   = s_q[k-1];
        carry_in = c_q[k-1];
        valid_in = v_q[k-1];
      end
      chunk = {1'b0, op_a[k*CW +: CW]} + {1'b0, op_b[k*CW +: CW]}
            + {{CW{1'b0}}, carry_in};
      a_d[k]              = op_a;
      b_d[k]              = op_b;
      s_d[k]              = part_s;
      s_d[k][k*CW +: CW]  = chunk[CW-1:0];
      c_d[k]              = chunk[CW];
      v_d[k]              = valid_in;
    end
    // After the loop op_a/op_b/chunk describe the last stage, which owns the
    // MSB: the carry into the MSB is recovered from its sum bit.
    msb_carry_in = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ chunk[CW-1];
    of_d         = msb_carry_in ^ chunk[CW];
`ifdef PIPE_ADDER_SAT_EN
    if (of_d) begin
      s_d[STAGES-1] = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q  <= '0;
      v_q  <= '0;
      of_q <= 1'b0;
    end else if (en) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q  <= c_d;
      v_q  <= v_d;
      of_q <= of_d;
    end
  end

  assign in_ready  = en;
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign of        = of_q;
  assign out_valid = v_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder
//   Directed and randomized checks of pipelined_adder (WIDTH=32, STAGES=4)
//   against a queue-based arithmetic reference model.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_i, b_i;
  logic        cin_i;
  logic        in_valid, in_ready;
  logic [31:0] sum;
  logic        cout, of, out_valid, out_ready;

  int compared   = 0;
  int mismatched = 0;

  logic [33:0] exp_q [$];

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a_i),
    .b         (b_i),
    .cin       (cin_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .of        (of),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] ref_res(logic [31:0] x, logic [31:0] y, logic ci);
    logic [32:0] full;
    logic [31:0] s;
    logic        ovf;
    full = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    s    = full[31:0];
    ovf  = (x[31] == y[31]) && (s[31] != x[31]);
`ifdef PIPE_ADDER_SAT_EN
    if (ovf) s = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {s, full[32], ovf};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are set by the caller just after a negedge;
  // handshakes are evaluated mid-cycle, before the rising edge.
  task automatic tick(output logic fi, output logic fo, output logic [33:0] obs);
    #1;
    fi  = in_valid && in_ready;
    fo  = out_valid && out_ready;
    obs = {sum, cout, of};
    if (fo) begin
      if (exp_q.size() == 0) chk("spurious_output", 64'(exp_q.size()), 64'd1);
      else                   chk("result", 64'(obs), 64'(exp_q.pop_front()));
    end
    if (fi) exp_q.push_back(ref_res(a_i, b_i, cin_i));
    @(negedge clk);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a, b;
    logic        ci;
    logic [31:0] s;
    logic        co, ov;
  } vec_t;

  vec_t vecs [6];

  task automatic run_single(input vec_t v);
    logic        fi, fo;
    logic [33:0] obs;
    int          lat;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a_i       = v.a;
    b_i       = v.b;
    cin_i     = v.ci;
    tick(fi, fo, obs);
    chk({v.tag, "_accept"}, 64'(fi), 64'd1);
    in_valid = 1'b0;
    lat = 0;
    fo  = 1'b0;
    while (!fo && lat < 20) begin
      tick(fi, fo, obs);
      lat++;
    end
    chk({v.tag, "_latency"}, 64'(lat), 64'd4);
    chk({v.tag, "_value"}, 64'(obs), 64'({v.s, v.co, v.ov}));
  endtask

  initial begin
    logic        fi, fo;
    logic [33:0] obs, held;
    int          sent, delivered, cyc, stall_left;
    logic        stall_done;

`ifdef PIPE_ADDER_SAT_EN
    vecs[0] = '{"max_pos_plus1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[1] = '{"min_neg_twice", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
`else
    vecs[0] = '{"max_pos_plus1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[1] = '{"min_neg_twice", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
`endif
    vecs[2] = '{"all_ones",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[3] = '{"ripple_3chunk", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    vecs[4] = '{"ripple_cin",    32'h0000_00FF, 32'h0000_0001, 1'b1, 32'h0000_0101, 1'b0, 1'b0};
    vecs[5] = '{"ripple_full",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    // Reset state
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_i       = '0;
    b_i       = '0;
    cin_i     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", 64'({sum, cout, of}), 64'd0);
    rst_n = 1'b1;

    // Directed vectors; the first is presented on the first edge after release
    foreach (vecs[i]) run_single(vecs[i]);

    // Eight back-to-back transfers with a 3-cycle consumer stall
    sent = 0; delivered = 0; cyc = 0; stall_left = 0; stall_done = 1'b0; held = '0;
    while ((sent < 8 || exp_q.size() > 0) && cyc < 200) begin
      if (out_valid && !stall_done) begin
        stall_done = 1'b1;
        stall_left = 3;
        held       = {sum, cout, of};
      end
      out_ready = (stall_left == 0);
      in_valid  = (sent < 8);
      a_i       = $urandom;
      b_i       = $urandom;
      cin_i     = 1'($urandom_range(0, 1));
      #1;
      if (stall_left > 0) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", 64'({sum, cout, of}), 64'(held));
        stall_left--;
      end
      tick(fi, fo, obs);
      if (fi) sent++;
      if (fo) delivered++;
      cyc++;
    end
    chk("stall_sent", 64'(sent), 64'd8);
    chk("stall_delivered", 64'(delivered), 64'd8);
    chk("stall_happened", 64'(stall_done), 64'd1);

    // Reset with three operations in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a_i      = $urandom;
      b_i      = $urandom;
      cin_i    = 1'($urandom_range(0, 1));
      tick(fi, fo, obs);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_outputs", 64'({sum, cout, of}), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_single(vecs[2]);

    // Randomized traffic
    sent = 0; cyc = 0;
    while ((sent < 10000 || exp_q.size() > 0) && cyc < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       begin a_i = 32'h7FFF_FFFF; b_i = $urandom; end
        1:       begin a_i = 32'h8000_0000; b_i = 32'h8000_0000 | $urandom; end
        default: begin a_i = $urandom; b_i = $urandom; end
      endcase
      cin_i = 1'($urandom_range(0, 1));
      tick(fi, fo, obs);
      if (fi) sent++;
      cyc++;
    end
    chk("random_sent", 64'(sent), 64'd10000);
    chk("random_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
